// File: rtl/seq_unsigned_divider.sv
// rtl/seq_unsigned_divider.sv - multi-cycle radix-2 restoring unsigned divider
//
// Computes quotient = dividend / divisor and remainder = dividend % divisor,
// one quotient bit per clock, with valid/ready handshakes on both sides.
// Results are registered and held until consumed, and stay held after hand-off.
//
// Optional feature macro: SEQ_DIV_FASTPATH_EN
//   When defined, dividend < divisor and divisor == 1 skip the iterative
//   path and complete in one cycle. Results are identical either way.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     operands valid
//   in_ready     divider idle and able to accept operands
//   dividend     unsigned dividend, WIDTH bits
//   divisor      unsigned divisor, WIDTH bits
//   out_valid    quotient/remainder/div_by_zero valid
//   out_ready    consumer accepts the result
//   quotient     unsigned quotient, WIDTH bits (all ones on divide-by-zero)
//   remainder    unsigned remainder, WIDTH bits (dividend on divide-by-zero)
//   div_by_zero  result came from a zero divisor
//   busy         high whenever not idle

module seq_unsigned_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;      // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] b_q;      // latched divisor
  logic [WIDTH-1:0] r_q;      // partial remainder
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] a_next;
  logic             fast_hit;

  // One restoring step. The shifted remainder can reach 2*B-1, so it needs
  // WIDTH+1 bits, and one more bit above that gives an unambiguous sign for
  // the trial subtraction even at dividend = all ones, divisor = 1.
  always_comb begin
    r_shift   = {r_q, a_q[WIDTH-1]};
    trial     = {1'b0, r_shift} - {2'b00, b_q};
    trial_neg = trial[WIDTH+1];
    r_next    = trial_neg ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    a_next    = {a_q[WIDTH-2:0], ~trial_neg};
  end

  always_comb begin
`ifdef SEQ_DIV_FASTPATH_EN
    fast_hit = (divisor != '0) && ((dividend < divisor) || (divisor == WIDTH'(1)));
`else
    fast_hit = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q <= dividend;
            b_q <= divisor;
            r_q <= '0;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              state_q <= ST_DONE;
            end else if (fast_hit) begin
              // divisor == 1 with dividend == 0 also satisfies dividend < divisor;
              // both branches agree on 0/0 there.
              quot_q  <= (divisor == WIDTH'(1)) ? dividend : '0;
              rem_q   <= (divisor == WIDTH'(1)) ? '0 : dividend;
              dbz_q   <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          a_q   <= a_next;
          r_q   <= r_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            quot_q  <= a_next;
            rem_q   <= r_next;
            dbz_q   <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// tb/tb_seq_unsigned_divider.sv - self-checking bench for seq_unsigned_divider

module tb_seq_unsigned_divider;

`ifdef SEQ_DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  dividend, divisor;
  logic        in_ready, out_valid, div_by_zero, busy;
  logic [7:0]  quotient, remainder;

  logic        in_valid16, out_ready16;
  logic [15:0] dividend16, divisor16;
  logic        in_ready16, out_valid16, div_by_zero16, busy16;
  logic [15:0] quotient16, remainder16;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_unsigned_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  seq_unsigned_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .dividend(dividend16), .divisor(divisor16), .out_valid(out_valid16),
    .out_ready(out_ready16), .quotient(quotient16), .remainder(remainder16),
    .div_by_zero(div_by_zero16), .busy(busy16)
  );

  // Clock edges after the accepting edge until out_valid is seen: the direct
  // path shows out_valid right after the accept edge, the iterative path after
  // WIDTH further edges.
  function automatic int exp_lat(input int w, input longint dd, input longint dv);
    if (dv == 0) return 0;
    if (FAST && (dd < dv || dv == 1)) return 0;
    return w;
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op8(input logic [7:0] dd, input logic [7:0] dv,
                        input int hold, input bit pulse_in, input string tag);
    int n;
    logic [7:0] eq, er;
    logic edbz;
    edbz = (dv == 0);
    eq   = edbz ? 8'hFF : 8'(int'(dd) / int'(dv));
    er   = edbz ? dd    : 8'(int'(dd) % int'(dv));
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s accept_wait: in_ready=%b required 1", tag, in_ready);
    else pass_cnt++;
    in_valid = 1'b1; dividend = dd; divisor = dv; out_ready = 1'b0;
    step();
    in_valid = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    total_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL %s busy_after_accept: busy=%b in_ready=%b required 1/0", tag, busy, in_ready);
    else pass_cnt++;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
    total_cnt++;
    if (n !== exp_lat(8, longint'(dd), longint'(dv)))
      $display("FAIL %s latency %0d/%0d: got %0d required %0d", tag, dd, dv, n, exp_lat(8, longint'(dd), longint'(dv)));
    else pass_cnt++;
    for (int i = 0; i < hold; i++) begin
      if (pulse_in) begin
        in_valid = 1'b1; dividend = 8'($urandom); divisor = 8'($urandom);
      end
      total_cnt++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, eq, er, edbz})
        $display("FAIL %s hold %0d/%0d: ov=%b ir=%b q=%0d r=%0d z=%b required 1 0 %0d %0d %b",
                 tag, dd, dv, out_valid, in_ready, quotient, remainder, div_by_zero, eq, er, edbz);
      else pass_cnt++;
      step();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (quotient !== eq) $display("FAIL %s quotient %0d/%0d: got %0d required %0d", tag, dd, dv, quotient, eq);
    else pass_cnt++;
    total_cnt++;
    if (remainder !== er) $display("FAIL %s remainder %0d/%0d: got %0d required %0d", tag, dd, dv, remainder, er);
    else pass_cnt++;
    total_cnt++;
    if (div_by_zero !== edbz || out_valid !== 1'b1)
      $display("FAIL %s dbz %0d/%0d: dbz=%b ov=%b required %b 1", tag, dd, dv, div_by_zero, out_valid, edbz);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, busy, quotient, remainder} !== {1'b0, 1'b1, 1'b0, eq, er})
      $display("FAIL %s handoff: ov=%b ir=%b busy=%b q=%0d r=%0d required 0 1 0 %0d %0d",
               tag, out_valid, in_ready, busy, quotient, remainder, eq, er);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; dividend16 = '0; divisor16 = '0;
    @(negedge clk);
    step(); step();
    total_cnt++;
    if ({in_ready, out_valid, busy, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0})
      $display("FAIL reset_state: ir=%b ov=%b busy=%b q=%0d r=%0d z=%b required 1 0 0 0 0 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    else pass_cnt++;
    total_cnt++;
    if ({in_ready16, out_valid16, busy16, quotient16, remainder16} !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0})
      $display("FAIL reset_state16: ir=%b ov=%b q=%0d r=%0d required 1 0 0 0",
               in_ready16, out_valid16, quotient16, remainder16);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    do_op8(8'd200, 8'd7, 0, 1'b0, "basic_200_7");
    do_op8(8'd255, 8'd1, 0, 1'b0, "max_div_one");
    do_op8(8'd5, 8'd200, 0, 1'b0, "small_over_big");
    do_op8(8'd255, 8'd255, 0, 1'b0, "equal_max");
  endtask

  task automatic test_div_zero;
    do_op8(8'd13, 8'd0, 0, 1'b0, "div_zero_13");
    do_op8(8'd0, 8'd0, 1, 1'b0, "div_zero_0");
  endtask

  task automatic test_backpressure;
    do_op8(8'd100, 8'd9, 5, 1'b1, "backpressure_100_9");
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    in_valid = 1'b1; dividend = 8'd250; divisor = 8'd3;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    total_cnt++;
    if ({out_valid, in_ready, busy, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0})
      $display("FAIL reset_mid_calc: ov=%b ir=%b busy=%b q=%0d r=%0d z=%b required 0 1 0 0 0 0",
               out_valid, in_ready, busy, quotient, remainder, div_by_zero);
    else pass_cnt++;
    rst = 1'b0;
    do_op8(8'd9, 8'd4, 0, 1'b0, "after_reset_9_4");
  endtask

  task automatic test_back_to_back;
    int n;
    bit overlap;
    overlap = 1'b0;
    in_valid = 1'b1; dividend = 8'd200; divisor = 8'd7; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    step();
    n = 0;
    while (!in_ready && n < 100) begin
      step(); n++;
      if (in_ready && out_valid) overlap = 1'b1;
    end
    total_cnt++;
    if (n + 1 !== 10) $display("FAIL back_to_back_spacing: got %0d required 10", n + 1);
    else pass_cnt++;
    total_cnt++;
    if (overlap) $display("FAIL back_to_back_overlap: in_ready and out_valid high together");
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
    total_cnt++;
    if ({quotient, remainder} !== {8'd28, 8'd4})
      $display("FAIL back_to_back_result: q=%0d r=%0d required 28 4", quotient, remainder);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random_w8;
    logic [7:0] dd, dv;
    for (int k = 0; k < 1000; k++) begin
      dd = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       dv = 8'd0;
        1:       dv = 8'd1;
        2:       dv = 8'($urandom_range(1, 15));
        default: dv = 8'($urandom);
      endcase
      do_op8(dd, dv, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand8");
    end
  endtask

  task automatic test_random_w16;
    logic [15:0] dd, dv, eq, er;
    logic edbz;
    int n, hold;
    for (int k = 0; k < 500; k++) begin
      dd = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       dv = 16'd0;
        1:       dv = 16'd1;
        2:       dv = 16'($urandom_range(1, 255));
        default: dv = 16'($urandom);
      endcase
      edbz = (dv == 0);
      eq   = edbz ? 16'hFFFF : 16'(int'(dd) / int'(dv));
      er   = edbz ? dd       : 16'(int'(dd) % int'(dv));
      n = 0;
      while (!in_ready16 && n < 50) begin step(); n++; end
      in_valid16 = 1'b1; dividend16 = dd; divisor16 = dv; out_ready16 = 1'b0;
      step();
      in_valid16 = 1'b0; dividend16 = 16'($urandom); divisor16 = 16'($urandom);
      n = 0;
      while (out_valid16 !== 1'b1 && n < 100) begin step(); n++; end
      total_cnt++;
      if (n !== exp_lat(16, longint'(dd), longint'(dv)))
        $display("FAIL rand16 latency %0d/%0d: got %0d required %0d", dd, dv, n, exp_lat(16, longint'(dd), longint'(dv)));
      else pass_cnt++;
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) step();
      total_cnt++;
      if ({out_valid16, quotient16, remainder16, div_by_zero16} !== {1'b1, eq, er, edbz})
        $display("FAIL rand16 result %0d/%0d: ov=%b q=%0d r=%0d z=%b required 1 %0d %0d %b",
                 dd, dv, out_valid16, quotient16, remainder16, div_by_zero16, eq, er, edbz);
      else pass_cnt++;
      out_ready16 = 1'b1;
      step();
      out_ready16 = 1'b0;
      total_cnt++;
      if ({out_valid16, in_ready16} !== 2'b01)
        $display("FAIL rand16 handoff: ov=%b ir=%b required 0 1", out_valid16, in_ready16);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_w8();
    test_random_w16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
